mau_reli_tx_seq_engine: RTL and testbench

// - Next-gen reliable-TX action stage: joins the PHV stream with the EM match-result stream and stamps the per-flow sequence number (RPN) and reset flag into the PHV.
// - Keeps per-flow {rst_flag, rpn} state in on-chip RAM. Provides flowmod write, read and clear-all access.
// - Sits after the EM table and the PHV delay FIFO in the mau_reli_tx pipeline. Replaces the fixed 32-bit single-mode action core.

---
 rtl/mau_reli_tx_pkg.sv | 30 +++
 rtl/mau_reli_tx_state_ram.sv | 29 ++
 rtl/mau_reli_tx_seq_engine.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mau_reli_tx_seq_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_reli_tx_pkg.sv
// Shared opcodes, FSM encoding and stats addresses for the reliable-TX
// sequence engine.
package mau_reli_tx_pkg;

    localparam logic [3:0] OP_WRITE = 4'hC;
    localparam logic [3:0] OP_READ  = 4'hD;
    localparam logic [3:0] OP_CLEAR = 4'hE;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [23:0] STAT_HIT_ADDR  = 24'hFFFFF0;
    localparam logic [23:0] STAT_MISS_ADDR = 24'hFFFFF1;
    localparam logic [23:0] STAT_WRAP_ADDR = 24'hFFFFF2;

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_HIT  = 2'd1,
        SEL_MISS = 2'd2,
        SEL_WRAP = 2'd3
    } rd_sel_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mau_reli_tx_state_ram.sv
// Per-flow {rst_flag, rpn} store: one write port, one registered read port.
// Read data holds while re is low so a frozen pipe keeps its operand.
module reli_tx_state_ram
    import mau_reli_tx_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mau_reli_tx_seq_engine.sv
// Reliable-TX action stage: joins PHV and EM result, stamps per-flow RPN.
// Optional stats counters are built when RELI_TX_STATS_EN is defined.
module mau_reli_tx_seq_engine
    import mau_reli_tx_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int RPN_WIDTH      = 32,
    parameter int PHV_WIDTH      = 408,
    parameter int RPN_OFFSET     = 0,
    parameter int FLAG_OFFSET    = 32,
    parameter int OPCODE_WIDTH   = 4,
    parameter int MOD_ADDR_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      s_phv_valid,
    output logic                      s_phv_ready,
    input  logic [PHV_WIDTH-1:0]      s_phv_info,
    input  logic                      s_mat_valid,
    output logic                      s_mat_ready,
    input  logic                      s_mat_hit,
    input  logic [ADDR_WIDTH-1:0]     s_mat_addr,
    output logic                      m_phv_valid,
    input  logic                      m_phv_ready,
    output logic [PHV_WIDTH-1:0]      m_phv_info,
    input  logic [MOD_ADDR_WIDTH-1:0] s_mod_addr,
    input  logic [RPN_WIDTH:0]        s_mod_data,
    input  logic [OPCODE_WIDTH-1:0]   s_mod_opcode,
    input  logic                      s_mod_valid,
    output logic                      s_mod_ready,
    output logic [RPN_WIDTH:0]        m_mod_bdata,
    output logic                      m_mod_bvalid,
    input  logic                      m_mod_bready
);

    localparam int DW = RPN_WIDTH + 1;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] swp_cnt;
    logic                  sweep;
    logic                  drain;
    logic                  mod_ok;
    logic                  mod_req;
    logic                  mod_fire;
    logic                  op_wr;
    logic                  op_rd;
    logic                  op_clr;
    logic                  adv;
    logic                  join_ok;
    logic                  wb;
    logic                  s1_adv;
    logic                  rd_issue;

    logic                  s1_valid;
    logic                  s1_hit;
    logic                  s1_stamp;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [PHV_WIDTH-1:0]  s1_phv;
    logic                  s1_fwd_v;
    logic [DW-1:0]         s1_fwd_d;
    logic [DW-1:0]         s1_data;
    logic [RPN_WIDTH-1:0]  s1_rpn;
    logic [RPN_WIDTH-1:0]  rpn_inc;
    logic                  s1_flag;
    logic                  s1_wrap;
    logic [DW-1:0]         wb_data;
    logic [PHV_WIDTH-1:0]  s1_out;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DW-1:0]         ram_wdata;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DW-1:0]         ram_rdata;
    logic [DW-1:0]         rb_data;

    assign op_wr  = s_mod_opcode == OPCODE_WIDTH'(OP_WRITE);
    assign op_rd  = s_mod_opcode == OPCODE_WIDTH'(OP_READ);
    assign op_clr = s_mod_opcode == OPCODE_WIDTH'(OP_CLEAR);

    assign adv   = ~m_phv_valid | m_phv_ready;
    assign drain = s1_valid | m_phv_valid;

    // A pending flowmod stalls new joins so S1 empties and the op can land
    assign mod_req     = mod_ok & s_mod_valid;
    assign s_mod_ready = mod_ok & ~s1_valid;
    assign mod_fire    = s_mod_valid & s_mod_ready;

    assign join_ok = (state == ST_RUN) & adv & ~mod_req
                   & s_phv_valid & s_mat_valid;
    assign s_phv_ready = join_ok;
    assign s_mat_ready = join_ok;

    assign s1_adv = adv & s1_valid;
    assign wb     = s1_adv & s1_stamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT, ST_CLEAR: begin
                if (sweep && (&swp_cnt)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mod_fire && op_clr) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        sweep  = 1'b0;
        mod_ok = 1'b0;
        unique case (state)
            ST_INIT:  sweep  = 1'b1;
            ST_RUN:   mod_ok = ~rd_issue & ~m_mod_bvalid;
            ST_CLEAR: sweep  = ~drain;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swp_cnt <= '0;
        end else if (sweep) begin
            swp_cnt <= swp_cnt + ADDR_WIDTH'(1);
        end
    end

    // Forwarded value wins over RAM data written on the same edge as the read
    assign s1_data = s1_fwd_v ? s1_fwd_d : ram_rdata;
    assign s1_rpn  = s1_data[RPN_WIDTH-1:0];
    assign s1_flag = s1_data[RPN_WIDTH];
    assign s1_wrap = &s1_rpn;
    assign rpn_inc = s1_rpn + RPN_WIDTH'(1);
    assign wb_data = {s1_wrap ? s1_flag : 1'b0, rpn_inc};

    always_comb begin
        s1_out = s1_phv;
        if (s1_stamp) begin
            s1_out[RPN_OFFSET +: RPN_WIDTH] = s1_rpn;
            s1_out[FLAG_OFFSET]             = s1_flag;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        unique case (1'b1)
            sweep: begin
                ram_we    = 1'b1;
                ram_waddr = swp_cnt;
                ram_wdata = {1'b1, {RPN_WIDTH{1'b0}}};
            end
            wb: begin
                ram_we    = 1'b1;
                ram_waddr = s1_addr;
                ram_wdata = wb_data;
            end
            (mod_fire && op_wr): begin
                ram_we    = 1'b1;
                ram_waddr = s_mod_addr[ADDR_WIDTH-1:0];
                ram_wdata = s_mod_data;
            end
            default: ;
        endcase
    end

    assign ram_re    = adv | (mod_fire & op_rd);
    assign ram_raddr = (mod_fire & op_rd)
                     ? s_mod_addr[ADDR_WIDTH-1:0] : s_mat_addr;

    reli_tx_state_ram #(
        .AW (ADDR_WIDTH),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_hit      <= 1'b0;
            s1_stamp    <= 1'b0;
            s1_addr     <= '0;
            s1_phv      <= '0;
            s1_fwd_v    <= 1'b0;
            s1_fwd_d    <= '0;
            m_phv_valid <= 1'b0;
            m_phv_info  <= '0;
        end else if (adv) begin
            s1_valid    <= join_ok;
            m_phv_valid <= s1_valid;
            if (join_ok) begin
                s1_hit   <= s_mat_hit;
                s1_stamp <= s_mat_hit & enable;
                s1_addr  <= s_mat_addr;
                s1_phv   <= s_phv_info;
                s1_fwd_v <= ram_we && (ram_waddr == s_mat_addr);
                s1_fwd_d <= ram_wdata;
            end
            if (s1_valid) begin
                m_phv_info <= s1_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_issue     <= 1'b0;
            m_mod_bvalid <= 1'b0;
            m_mod_bdata  <= '0;
        end else begin
            rd_issue <= mod_fire & op_rd;
            if (rd_issue) begin
                m_mod_bvalid <= 1'b1;
                m_mod_bdata  <= rb_data;
            end else if (m_mod_bready) begin
                m_mod_bvalid <= 1'b0;
            end
        end
    end

`ifdef RELI_TX_STATS_EN
    logic [31:0] cnt_hit;
    logic [31:0] cnt_miss;
    logic [31:0] cnt_wrap;
    rd_sel_t     rd_sel;
    rd_sel_t     rd_sel_nxt;

    always_comb begin
        rd_sel_nxt = SEL_RAM;
        unique case (1'b1)
            (s_mod_addr == MOD_ADDR_WIDTH'(STAT_HIT_ADDR)):
                rd_sel_nxt = SEL_HIT;
            (s_mod_addr == MOD_ADDR_WIDTH'(STAT_MISS_ADDR)):
                rd_sel_nxt = SEL_MISS;
            (s_mod_addr == MOD_ADDR_WIDTH'(STAT_WRAP_ADDR)):
                rd_sel_nxt = SEL_WRAP;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_hit  <= '0;
            cnt_miss <= '0;
            cnt_wrap <= '0;
            rd_sel   <= SEL_RAM;
        end else begin
            if (mod_fire && op_rd) begin
                rd_sel <= rd_sel_nxt;
            end
            if (s1_adv && s1_stamp) begin
                cnt_hit <= sat_inc(cnt_hit);
            end
            if (s1_adv && !s1_hit) begin
                cnt_miss <= sat_inc(cnt_miss);
            end
            if (s1_adv && s1_stamp && s1_wrap) begin
                cnt_wrap <= sat_inc(cnt_wrap);
            end
        end
    end

    always_comb begin
        unique case (rd_sel)
            SEL_HIT:  rb_data = DW'(cnt_hit);
            SEL_MISS: rb_data = DW'(cnt_miss);
            SEL_WRAP: rb_data = DW'(cnt_wrap);
            default:  rb_data = ram_rdata;
        endcase
    end
`else
    logic unused_ok;

    assign rb_data   = ram_rdata;
    assign unused_ok = ^{s_mod_addr[MOD_ADDR_WIDTH-1:ADDR_WIDTH], s1_hit};
`endif

endmodule

// File: tb/tb_mau_reli_tx_seq_engine.sv
// Scoreboard bench for the reliable-TX sequence engine with a flow-table
// model; stats reads are exercised when RELI_TX_STATS_EN is defined.
module tb_mau_reli_tx_seq_engine;

    localparam int AW = 11;
    localparam int RW = 32;
    localparam int PW = 408;
    localparam int DW = 33;
    localparam int MW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          s_phv_valid = 1'b0;
    logic          s_phv_ready;
    logic [PW-1:0] s_phv_info = '0;
    logic          s_mat_valid = 1'b0;
    logic          s_mat_ready;
    logic          s_mat_hit = 1'b0;
    logic [AW-1:0] s_mat_addr = '0;
    logic          m_phv_valid;
    logic          m_phv_ready = 1'b1;
    logic [PW-1:0] m_phv_info;
    logic [MW-1:0] s_mod_addr = '0;
    logic [DW-1:0] s_mod_data = '0;
    logic [3:0]    s_mod_opcode = '0;
    logic          s_mod_valid = 1'b0;
    logic          s_mod_ready;
    logic [DW-1:0] m_mod_bdata;
    logic          m_mod_bvalid;
    logic          m_mod_bready = 1'b1;

    always #5 clk = ~clk;

    mau_reli_tx_seq_engine dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_phv_valid  (s_phv_valid),
        .s_phv_ready  (s_phv_ready),
        .s_phv_info   (s_phv_info),
        .s_mat_valid  (s_mat_valid),
        .s_mat_ready  (s_mat_ready),
        .s_mat_hit    (s_mat_hit),
        .s_mat_addr   (s_mat_addr),
        .m_phv_valid  (m_phv_valid),
        .m_phv_ready  (m_phv_ready),
        .m_phv_info   (m_phv_info),
        .s_mod_addr   (s_mod_addr),
        .s_mod_data   (s_mod_data),
        .s_mod_opcode (s_mod_opcode),
        .s_mod_valid  (s_mod_valid),
        .s_mod_ready  (s_mod_ready),
        .m_mod_bdata  (m_mod_bdata),
        .m_mod_bvalid (m_mod_bvalid),
        .m_mod_bready (m_mod_bready)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] flow [2**AW];
    logic [PW-1:0] phv_q [$];
    logic [DW-1:0] rd_q [$];
    int n_hit = 0;
    int n_miss = 0;
    int n_wrap = 0;
    bit rnd_rdy = 1'b0;
    bit stall = 1'b0;

    task automatic chk(input string nm, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    function automatic logic [PW-1:0] rnd_phv();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    task automatic send(input logic [AW-1:0] a, input logic h,
                        input logic en);
        logic [PW-1:0] v;
        logic [PW-1:0] e;
        logic [RW-1:0] rpn;
        logic          flg;
        bit            done;
        done = 1'b0;
        v = rnd_phv();
        s_phv_info  = v;
        s_mat_addr  = a;
        s_mat_hit   = h;
        enable      = en;
        s_phv_valid = 1'b1;
        s_mat_valid = 1'b1;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (s_phv_ready && s_mat_ready) begin
                e = v;
                if (h && en) begin
                    rpn = flow[a][RW-1:0];
                    flg = flow[a][RW];
                    e[RW-1:0] = rpn;
                    e[32] = flg;
                    if (rpn == 32'hFFFF_FFFF) n_wrap++;
                    else flg = 1'b0;
                    flow[a] = {flg, rpn + 32'd1};
                    n_hit++;
                end
                if (!h) n_miss++;
                phv_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_phv_valid = 1'b0;
        s_mat_valid = 1'b0;
        if (!done) timeout("send");
    endtask

    task automatic mod_op(input logic [3:0] op, input logic [MW-1:0] a,
                          input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        s_mod_opcode = op;
        s_mod_addr   = a;
        s_mod_data   = d;
        s_mod_valid  = 1'b1;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (s_mod_ready) begin
                done = 1'b1;
                if (op == 4'hC) flow[a[AW-1:0]] = d;
                if (op == 4'hE) begin
                    for (int k = 0; k < 2**AW; k++) flow[k] = {1'b1, 32'd0};
                end
                if (op == 4'hD) begin
`ifdef RELI_TX_STATS_EN
                    if (a == 24'hFFFFF0) rd_q.push_back(DW'(n_hit));
                    else if (a == 24'hFFFFF1) rd_q.push_back(DW'(n_miss));
                    else if (a == 24'hFFFFF2) rd_q.push_back(DW'(n_wrap));
                    else rd_q.push_back(flow[a[AW-1:0]]);
`else
                    rd_q.push_back(flow[a[AW-1:0]]);
`endif
                end
            end
            @(posedge clk);
            #1;
        end
        s_mod_valid = 1'b0;
        if (!done) timeout("mod_op");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                m_phv_ready  = ($urandom % 3) != 0;
                m_mod_bready = ($urandom % 2) != 0;
            end else begin
                m_phv_ready  = !stall;
                m_mod_bready = 1'b1;
            end
        end
    end

    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (m_phv_valid === 1'b1 && m_phv_ready) begin
                if (phv_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL phv_extra actual=%h required=none",
                             m_phv_info);
                end else begin
                    e = phv_q.pop_front();
                    chk("phv", m_phv_info, e);
                end
            end
            if (m_mod_bvalid === 1'b1 && m_mod_bready) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bdata_extra actual=%h required=none",
                             m_mod_bdata);
                end else begin
                    chk("bdata", PW'(m_mod_bdata), PW'(rd_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int r;
        for (int k = 0; k < 2**AW; k++) flow[k] = {1'b1, 32'd0};

        s_phv_valid = 1'b1;
        s_mat_valid = 1'b1;
        s_mat_hit   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_phv_valid", PW'(m_phv_valid), '0);
        chk("rst_m_phv_info", m_phv_info, '0);
        chk("rst_bvalid", PW'(m_mod_bvalid), '0);
        chk("rst_bdata", PW'(m_mod_bdata), '0);
        chk("rst_phv_ready", PW'(s_phv_ready), '0);
        chk("rst_mat_ready", PW'(s_mat_ready), '0);
        chk("rst_mod_ready", PW'(s_mod_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 2046; i++) begin
            @(negedge clk);
            if (i % 512 == 0 || i == 2045) begin
                chk("init_phv_ready", PW'(s_phv_ready), '0);
                chk("init_mod_ready", PW'(s_mod_ready), '0);
            end
        end
        s_phv_valid = 1'b0;
        s_mat_valid = 1'b0;
        @(posedge clk);
        #1;
        mod_op(4'hD, 24'd5, '0);

        for (int i = 0; i < 3; i++) send(11'd7, 1'b1, 1'b1);
        mod_op(4'hD, 24'd7, '0);

        mod_op(4'hC, 24'd9, {1'b0, 32'hFFFF_FFFF});
        send(11'd9, 1'b1, 1'b1);
        send(11'd9, 1'b1, 1'b1);
        mod_op(4'hD, 24'd9, '0);

        send(11'd7, 1'b0, 1'b1);
        send(11'd7, 1'b1, 1'b0);
        mod_op(4'hD, 24'd7, '0);

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(11'd3, 1'b1, 1'b1);
                    send(11'd3, 1'b1, 1'b1);
                    send(11'd4, 1'b1, 1'b1);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                stall = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                stall = 1'b0;
            end
        join
        mod_op(4'hD, 24'd3, '0);
        mod_op(4'hD, 24'd4, '0);

        send(11'd3, 1'b1, 1'b1);
        send(11'd4, 1'b1, 1'b1);
        mod_op(4'hE, '0, '0);
        mod_op(4'hD, 24'd3, '0);
        mod_op(4'hD, 24'd4, '0);
        mod_op(4'hD, 24'd7, '0);
        mod_op(4'hD, 24'd2047, '0);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom % 10;
            if (r < 7) begin
                send(AW'($urandom % 8), ($urandom % 4) != 0,
                     ($urandom % 5) != 0);
            end else if (r == 7) begin
                mod_op(4'hC, MW'($urandom % 8),
                       {1'($urandom), 32'hFFFF_FFFE + 32'($urandom % 2)});
            end else if (r == 8) begin
                mod_op(4'hD, MW'($urandom % 8), '0);
            end else begin
                mod_op(4'($urandom % 12), MW'($urandom % 8), DW'($urandom));
            end
            if ($urandom % 3 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 1'b0;
        for (int k = 0; k < 8; k++) mod_op(4'hD, MW'(k), '0);
`ifdef RELI_TX_STATS_EN
        mod_op(4'hD, 24'hFFFFF0, '0);
        mod_op(4'hD, 24'hFFFFF1, '0);
        mod_op(4'hD, 24'hFFFFF2, '0);
`endif

        for (int i = 0; i < 500; i++) begin
            if (phv_q.size() == 0 && rd_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        chk("phv_q_drained", PW'(phv_q.size()), '0);
        chk("rd_q_drained", PW'(rd_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
